// File: rtl/fetch_controller_if.sv
// Instruction-memory handshake bundle between the fetch controller and the
// instruction memory.
//   imem_req_o    controller -> memory  request strobe
//   imem_addr_o   controller -> memory  request address (current PC)
//   imem_gnt_i    memory -> controller  request accepted this cycle
//   imem_rvalid_i memory -> controller  response valid (one per grant)
//   imem_rdata_i  memory -> controller  response instruction word
// master: fetch controller side; slave: memory side.
interface fetch_controller_if #(
  parameter int XLEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_controller.sv
// Fetch-stage sequencing controller.
// Owns the PC, runs a single-outstanding request/grant/response handshake to
// instruction memory and loads the fetch/decode pipeline register. Applies
// decode stalls and execute-stage redirects, and drops responses that were
// made stale by a redirect.
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   imem            instruction-memory handshake (master modport)
//   redirect_i      execute-stage branch/jump taken
//   redirect_pc_i   redirect target, used verbatim
//   stall_d_i       decode cannot accept a new instruction
//   instr_d_o       decode-register instruction
//   pc_d_o          decode-register PC
//   pcplus4_d_o     decode-register PC+4
//   valid_d_o       decode register holds a live instruction
module fetch_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_controller_if.master  imem,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  input  logic                stall_d_i,
  output logic [XLEN-1:0]     instr_d_o,
  output logic [XLEN-1:0]     pc_d_o,
  output logic [XLEN-1:0]     pcplus4_d_o,
  output logic                valid_d_o
);

  typedef enum logic [2:0] {
    S_IDLE,   // out of reset, one cycle before the first request
    S_FETCH,  // request asserted, waiting for grant
    S_WAIT,   // granted, waiting for the live response
    S_KILL,   // granted, response is stale and will be dropped
    S_HOLD    // response captured, decode register still busy
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } dec_t;

  state_t          state_q;
  logic            req_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;   // address of the outstanding/held request
  logic [XLEN-1:0] hold_q;     // response parked while decode is stalled
  dec_t            dec_q;
  logic            valid_q;

  logic            dec_busy;
  logic [XLEN-1:0] req_pc_p4;
  logic            load_wait;
  logic            load_hold;
  dec_t            dec_new;

  // Decode register only refuses data when it holds something and is stalled.
  assign dec_busy  = valid_q & stall_d_i;
  assign req_pc_p4 = req_pc_q + XLEN'(4);

  assign load_wait = (state_q == S_WAIT) & imem.imem_rvalid_i & ~redirect_i & ~dec_busy;
  assign load_hold = (state_q == S_HOLD) & ~redirect_i & ~dec_busy;

  always_comb begin
    dec_new.instr   = (state_q == S_HOLD) ? hold_q : imem.imem_rdata_i;
    dec_new.pc      = req_pc_q;
    dec_new.pcplus4 = req_pc_p4;
  end

  // Request is a registered output: req_q is set exactly when the next state
  // is FETCH, so the memory sees no combinational path from any input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      hold_q   <= '0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          req_q <= 1'b1;
          if (redirect_i) pc_q <= redirect_pc_i;
          if (imem.imem_gnt_i) begin
            req_q <= 1'b0;
            if (redirect_i) begin
              state_q <= S_KILL;
            end else begin
              state_q  <= S_WAIT;
              req_pc_q <= pc_q;
            end
          end
        end
        S_WAIT: begin
          if (redirect_i) begin
            pc_q <= redirect_pc_i;
            if (imem.imem_rvalid_i) begin
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end else begin
              state_q <= S_KILL;
            end
          end else if (imem.imem_rvalid_i) begin
            if (!dec_busy) begin
              pc_q    <= req_pc_p4;
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end else begin
              hold_q  <= imem.imem_rdata_i;
              state_q <= S_HOLD;
            end
          end
        end
        S_KILL: begin
          // A response that lands together with a new redirect still retires
          // the outstanding grant; staying here would wait forever.
          if (redirect_i) pc_q <= redirect_pc_i;
          if (imem.imem_rvalid_i) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end else if (!dec_busy) begin
            pc_q    <= req_pc_p4;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Decode register: flush beats stall, stall beats load, otherwise bubble
  // with data fields left untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else if (redirect_i) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else if (dec_busy) begin
      dec_q   <= dec_q;
      valid_q <= valid_q;
    end else if (load_wait || load_hold) begin
      dec_q   <= dec_new;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;
  assign instr_d_o        = dec_q.instr;
  assign pc_d_o           = dec_q.pc;
  assign pcplus4_d_o      = dec_q.pcplus4;
  assign valid_d_o        = valid_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller. A transaction-level model tracks
// the architectural next-PC stream: every decode load must be the next PC in
// program order, redirects restart the stream at the target and flush decode,
// and stalls freeze the decode fields. A second instance with a wrapping
// reset PC checks modulo arithmetic.
module tb_fetch_controller;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_controller_if #(.XLEN(XLEN)) bus ();
  fetch_controller_if #(.XLEN(XLEN)) bus2 ();

  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            stall = 1'b0;
  logic [XLEN-1:0] instr_d, pc_d, pc4_d;
  logic            valid_d;
  logic [XLEN-1:0] instr_d2, pc_d2, pc4_d2;
  logic            valid_d2;

  fetch_controller #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem(bus),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_d_i(stall),
    .instr_d_o(instr_d), .pc_d_o(pc_d), .pcplus4_d_o(pc4_d), .valid_d_o(valid_d)
  );

  fetch_controller #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem(bus2),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .stall_d_i(1'b0),
    .instr_d_o(instr_d2), .pc_d_o(pc_d2), .pcplus4_d_o(pc4_d2), .valid_d_o(valid_d2)
  );

  int total = 0;
  int bad   = 0;

  // memory model state
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  int          gnt_pct = 100, lat_lo = 1, lat_hi = 1, force_gnt = 1;
  bit          g2p = 0;
  logic [31:0] a2p = '0;

  // reference model state
  logic [31:0] exp_pc = '0;
  logic        bv;
  logic [31:0] bi, bp, b4;
  int          loads = 0, grants = 0, idle_run = 0, since_rel = 0;
  bit          gnt_seen = 0;
  logic [31:0] last_gnt_addr = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r_rst, input bit red, input logic [31:0] tgt, input bit stl);
    bit g, rv;
    @(negedge clk);
    bv = valid_d; bi = instr_d; bp = pc_d; b4 = pc4_d;
    gnt_seen = 0;
    if (!r_rst || since_rel < 1) red = 0;
    rst = r_rst;
    // main memory: one outstanding request, fixed-per-grant latency
    rv = 0;
    bus.imem_rdata_i = $urandom;
    if (pend) begin
      if (cnt == 0) begin
        rv = 1; pend = 0;
        bus.imem_rdata_i = word_of(paddr);
      end else cnt--;
    end
    g = 0;
    if (bus.imem_req_o && !pend && !rv)
      g = (force_gnt >= 0) ? force_gnt[0] : ($urandom_range(99) < gnt_pct);
    if (g) begin
      pend = 1; paddr = bus.imem_addr_o;
      cnt = $urandom_range(lat_hi, lat_lo) - 1;
      grants++; gnt_seen = 1; last_gnt_addr = paddr;
    end
    bus.imem_rvalid_i = rv;
    bus.imem_gnt_i    = g;
    // second memory: always grants, answers the next cycle
    bus2.imem_rvalid_i = g2p;
    bus2.imem_rdata_i  = word_of(a2p);
    bus2.imem_gnt_i    = bus2.imem_req_o;
    g2p = bus2.imem_req_o;
    if (bus2.imem_req_o) a2p = bus2.imem_addr_o;
    redirect = red; redirect_pc = tgt; stall = stl;
    @(posedge clk);
    #1;
    if (!r_rst) begin
      chk("rst_req", bus.imem_req_o, 0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);
      chk("rst_instr", instr_d, 0);
      chk("rst_pc", pc_d, 0);
      chk("rst_pc4", pc4_d, 0);
      chk("rst_valid", valid_d, 0);
      chk("rst_addr2", bus2.imem_addr_o, 32'hFFFF_FFFC);
      exp_pc = 32'h0; since_rel = 0; idle_run = 0;
    end else begin
      since_rel++;
      idle_run++;
      if (red) begin
        chk("flush_valid", valid_d, 0);
        chk("flush_instr", instr_d, 0);
        chk("flush_pc", pc_d, 0);
        chk("flush_pc4", pc4_d, 0);
        chk("redir_addr", bus.imem_addr_o, tgt);
        exp_pc = tgt;
      end else if (stl && bv) begin
        chk("stall_valid", valid_d, 1);
        chk("stall_instr", instr_d, bi);
        chk("stall_pc", pc_d, bp);
        chk("stall_pc4", pc4_d, b4);
      end else if (valid_d === 1'b1) begin
        chk("load_pc", pc_d, exp_pc);
        chk("load_pc4", pc4_d, exp_pc + 32'd4);
        chk("load_instr", instr_d, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        loads++; idle_run = 0;
        chk("load_le_grant", 32'(loads <= grants), 1);
      end else begin
        chk("bubble_valid", valid_d, 0);
        chk("bubble_instr", instr_d, bi);
        chk("bubble_pc", pc_d, bp);
        chk("bubble_pc4", pc4_d, b4);
      end
      if (idle_run > 120) begin
        chk("liveness", 32'(idle_run), 0);
        idle_run = 0;
      end
    end
  endtask

  task automatic run_until_gnt(input string tag);
    int n = 0;
    do begin step(1, 0, 0, 0); n++; end while (!gnt_seen && n < 40);
    chk(tag, 32'(gnt_seen), 1);
  endtask

  task automatic run_until_req(input string tag);
    int n = 0;
    while (bus.imem_req_o !== 1'b1 && n < 40) begin step(1, 0, 0, 0); n++; end
    chk(tag, bus.imem_req_o, 1);
  endtask

  initial begin
    logic [31:0] held;
    bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = 0;
    bus2.imem_gnt_i = 0; bus2.imem_rvalid_i = 0; bus2.imem_rdata_i = 0;

    // reset, then back-to-back best-case fetches
    repeat (3) step(0, 0, 0, 0);
    force_gnt = 1; lat_lo = 1; lat_hi = 1;
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 0, 0);
      chk($sformatf("basic_valid_%0d", k), valid_d, 32'((k >= 3) && (k % 2 == 1)));
      chk($sformatf("basic_req_%0d", k), bus.imem_req_o, 32'(k % 2 == 1));
      if (k == 3) begin
        chk("wrap_valid", valid_d2, 1);
        chk("wrap_pc", pc_d2, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4_d2, 32'h0);
        chk("wrap_instr", instr_d2, word_of(32'hFFFF_FFFC));
        chk("wrap_next_addr", bus2.imem_addr_o, 32'h0);
      end
    end

    // stall while valid and the next response returns
    step(1, 0, 0, 0);
    chk("pre_stall_valid", valid_d, 1);
    held = pc_d;
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 1);
      chk("stall_no_req", bus.imem_req_o, 0);
    end
    step(1, 0, 0, 0);
    chk("stall_release_valid", valid_d, 1);
    chk("stall_release_pc", pc_d, held + 32'd4);

    // redirect in WAIT, response 3 cycles later
    lat_lo = 4; lat_hi = 4;
    run_until_gnt("wait_gnt");
    step(1, 1, 32'h0000_0100, 0);
    chk("wait_redir_kill", bus.imem_req_o, 0);
    run_until_gnt("wait_refetch_gnt");
    chk("wait_refetch_addr", last_gnt_addr, 32'h0000_0100);

    // redirect in FETCH without grant
    lat_lo = 1; lat_hi = 1; force_gnt = 0;
    run_until_req("nogrant_req");
    step(1, 1, 32'h0000_0200, 0);
    chk("nogrant_still_req", bus.imem_req_o, 1);
    chk("nogrant_addr", bus.imem_addr_o, 32'h0000_0200);
    force_gnt = 1;
    run_until_gnt("nogrant_gnt");
    chk("nogrant_gnt_addr", last_gnt_addr, 32'h0000_0200);

    // redirect in FETCH together with grant
    run_until_req("grant_req");
    step(1, 1, 32'h0000_0300, 0);
    chk("grant_kill_req", bus.imem_req_o, 0);
    chk("grant_kill_addr", bus.imem_addr_o, 32'h0000_0300);
    step(1, 0, 0, 0);
    chk("grant_kill_discard", valid_d, 0);
    run_until_gnt("grant_refetch_gnt");
    chk("grant_refetch_addr", last_gnt_addr, 32'h0000_0300);

    // reset during WAIT, stale response arrives after release
    lat_lo = 4; lat_hi = 4;
    run_until_gnt("rst_wait_gnt");
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    run_until_gnt("post_rst_gnt");
    chk("post_rst_addr", last_gnt_addr, 32'h0);

    // randomized traffic
    force_gnt = -1; gnt_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 3000; k++) begin
      bit          r;
      logic [31:0] t;
      r = ($urandom_range(99) < 5);
      t = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      step(1, r, t, ($urandom_range(99) < 30));
    end
    chk("random_progress", 32'(loads > 200), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
